mem_arbiter: RTL

Two-requester memory controller sitting between the icache/dcache and the RAM side of the cpu-ram interface. It accepts icache fetch reads and dcache reads/writes, and grants one at a time. It drives memaddr/memREN/memWEN/memstore, holding them stable until ramstate reports completion. It then returns load data and a one-cycle done pulse to the granted requester, with a watchdog for hung transactions.

---
 rtl/mem_types_pkg.sv | 35 +++
 rtl/rr_arbiter2.sv | 40 ++++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mem_types_pkg.sv
// Shared memory-side types: RAM handshake state, data word, arbiter state/grant codes
// and the packed command that the arbiter presents to the RAM.
package mem_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM encoding kept as plain constants for older tools that consume it.
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t SERVE_I = 2'd1;
  localparam arb_state_t SERVE_D = 2'd2;
  localparam arb_state_t RESP    = 2'd3;

  typedef logic arb_grant_t;
  localparam arb_grant_t ICACHE = 1'b0;
  localparam arb_grant_t DCACHE = 1'b1;

  // Command held on the RAM port for the whole serve window.
  typedef struct packed {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t store;
  } mem_cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter between icache and dcache: combinational grant, registered last
// winner for round-robin tie breaking, optional fixed dcache priority.
module rr_arbiter2
  import mem_types_pkg::*;
#(
  parameter bit FIXED_DPRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_icache,
  input  logic       req_dcache,
  input  logic       update,
  output logic       any_c,
  output arb_grant_t grant_c
);

  arb_grant_t last_grant;

  assign any_c = req_icache | req_dcache;

  // Pick a winner; on a tie either dcache is forced or the previous loser goes next.
  always_comb begin
    grant_c = ICACHE;
    if (req_dcache && !req_icache) begin
      grant_c = DCACHE;
    end else if (req_dcache && req_icache) begin
      grant_c = (FIXED_DPRIO || (last_grant == ICACHE)) ? DCACHE : ICACHE;
    end
  end

  // Remember who was granted last; reset favours dcache on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ICACHE;
    end else if (update && any_c) begin
      last_grant <= grant_c;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Icache/dcache to RAM controller: grants one requester at a time, holds the RAM
// command until ACCESS/ERROR or watchdog expiry, then returns data with a done pulse.
module mem_arbiter
  import mem_types_pkg::*;
#(
  parameter bit          FIXED_DPRIO    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      i_req,
  input  word_t     i_addr,
  output logic      i_done,
  output word_t     i_load,
  input  logic      d_ren,
  input  logic      d_wen,
  input  word_t     d_addr,
  input  word_t     d_store,
  output logic      d_done,
  output word_t     d_load,
  output logic      err,
  output logic      memREN,
  output logic      memWEN,
  output word_t     memaddr,
  output word_t     memstore,
  input  ramstate_t ramstate,
  input  word_t     ramload
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  mem_cmd_t         cmd;
  mem_cmd_t         cmd_nxt;
  logic             i_done_nxt;
  logic             d_done_nxt;
  word_t            i_load_nxt;
  word_t            d_load_nxt;
  logic             err_nxt;
  logic             grant_en_c;
  logic             any_c;
  arb_grant_t       grant_c;
  logic             timeout_c;

  rr_arbiter2 #(
    .FIXED_DPRIO(FIXED_DPRIO)
  ) u_arb (
    .clk       (CLK),
    .rst       (RST),
    .req_icache(i_req),
    .req_dcache(d_ren | d_wen),
    .update    (grant_en_c),
    .any_c     (any_c),
    .grant_c   (grant_c)
  );

  assign timeout_c = TO_EN && (cnt == TO_LAST);

  // Next state and next registered outputs.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    cmd_nxt    = cmd;
    i_done_nxt = 1'b0;
    d_done_nxt = 1'b0;
    i_load_nxt = '0;
    d_load_nxt = '0;
    err_nxt    = 1'b0;
    grant_en_c = 1'b0;
    case (state)
      IDLE: begin
        cmd_nxt = '0;
        if (any_c) begin
          grant_en_c = 1'b1;
          if (grant_c == DCACHE) begin
            // A write wins over a simultaneous read request.
            state_nxt     = SERVE_D;
            cmd_nxt.addr  = d_addr;
            cmd_nxt.wen   = d_wen;
            cmd_nxt.ren   = ~d_wen;
            cmd_nxt.store = d_wen ? d_store : '0;
          end else begin
            state_nxt    = SERVE_I;
            cmd_nxt.addr = i_addr;
            cmd_nxt.ren  = 1'b1;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        cnt_nxt = cnt + CNT_W'(1);
        if ((ramstate == ACCESS) || (ramstate == ERROR) || timeout_c) begin
          // Completion has priority over the watchdog; anything but ACCESS is an error.
          state_nxt = RESP;
          cmd_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = (ramstate != ACCESS);
          if (state == SERVE_I) begin
            i_done_nxt = 1'b1;
            if (ramstate == ACCESS) i_load_nxt = ramload;
          end else begin
            d_done_nxt = 1'b1;
            if ((ramstate == ACCESS) && cmd.ren) d_load_nxt = ramload;
          end
        end
      end
      RESP: begin
        state_nxt = IDLE;
        cmd_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cmd_nxt   = '0;
      end
    endcase
  end

  // State, watchdog and output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      cmd    <= '0;
      i_done <= 1'b0;
      d_done <= 1'b0;
      i_load <= '0;
      d_load <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cmd    <= cmd_nxt;
      i_done <= i_done_nxt;
      d_done <= d_done_nxt;
      i_load <= i_load_nxt;
      d_load <= d_load_nxt;
      err    <= err_nxt;
    end
  end

  assign memREN   = cmd.ren;
  assign memWEN   = cmd.wen;
  assign memaddr  = cmd.addr;
  assign memstore = cmd.store;

endmodule
